// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - one-at-a-time ALU operation sequencer with C/Z flag ownership
module alu_op_sequencer #(
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_opcode,
  input  logic              req_func7,
  input  logic [2:0]        req_func3,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [3:0]        alu_control,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_cout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              flag_c,
  output logic              flag_z,
  output logic              busy
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [3:0] CODE_MULS = 4'd5;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MULW, S_RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        dec_code;
  logic [3:0]        code_q;
  logic [1:0]        opcode_q;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              mul_wait;
  logic              capture;
  logic              driving;

  always_comb begin
    dec_code = 4'd0;
    case (req_opcode)
      2'b01: dec_code = 4'd1;
      2'b10: begin
        case ({req_func7, req_func3})
          4'b0_000: dec_code = 4'd0;
          4'b1_000: dec_code = 4'd1;
          4'b0_001: dec_code = 4'd2;
          4'b1_001: dec_code = 4'd3;
          4'b1_010: dec_code = 4'd4;
          4'b1_011: dec_code = 4'd5;
          4'b0_111: dec_code = 4'd6;
          4'b0_110: dec_code = 4'd7;
          4'b1_111: dec_code = 4'd8;
          default:  dec_code = 4'd0;
        endcase
      end
      default: dec_code = 4'd0;
    endcase
  end

  assign accept   = (state == S_IDLE) && req_valid;
  // With MUL_CYCLES==1 a multiply finishes in EXEC like any other op.
  assign mul_wait = (code_q == CODE_MULS) && (MUL_CYCLES > 1);
  assign capture  = ((state == S_EXEC) && !mul_wait) ||
                    ((state == S_MULW) && (cnt == CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_valid) state_nxt = S_EXEC;
      S_EXEC: state_nxt = mul_wait ? S_MULW : S_RESP;
      S_MULW: if (cnt == CNT_W'(1)) state_nxt = S_RESP;
      S_RESP: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    driving     = (state == S_EXEC) || (state == S_MULW);
    req_ready   = (state == S_IDLE);
    busy        = (state != S_IDLE);
    rsp_valid   = (state == S_RESP);
    alu_control = driving ? code_q : 4'd0;
    alu_cin     = driving && ((code_q == 4'd0) || (code_q == 4'd2)) && flag_c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_q     <= 4'd0;
      opcode_q   <= 2'd0;
      alu_a      <= '0;
      alu_b      <= '0;
      cnt        <= '0;
      rsp_result <= '0;
      flag_c     <= 1'b0;
      flag_z     <= 1'b0;
    end else begin
      if (accept) begin
        code_q   <= dec_code;
        opcode_q <= req_opcode;
        alu_a    <= req_a;
        alu_b    <= req_b;
      end
      if ((state == S_EXEC) && mul_wait) cnt <= CNT_W'(MUL_CYCLES - 1);
      else if (state == S_MULW)          cnt <= cnt - CNT_W'(1);
      if (capture) begin
        rsp_result <= alu_result;
        // Only R-type ops are architectural flag writers; C only for add/sub family.
        if (opcode_q == 2'b10) begin
          flag_z <= (alu_result == '0);
          if (code_q <= 4'd4) flag_c <= alu_cout;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;
  localparam int DW = 32;
  localparam int MC = 4;

  logic          clk, rst_n, req_valid, req_ready, req_func7, alu_cin, alu_cout;
  logic          rsp_valid, rsp_ready, flag_c, flag_z, busy;
  logic [1:0]    req_opcode;
  logic [2:0]    req_func3;
  logic [3:0]    alu_control;
  logic [DW-1:0] req_a, req_b, alu_a, alu_b, alu_result, rsp_result;

  int   checks = 0;
  int   failures = 0;
  int   mul_k = 0;
  logic m_c = 1'b0;
  logic m_z = 1'b0;

  alu_op_sequencer #(.DATA_W(DW), .MUL_CYCLES(MC)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_func7(req_func7), .req_func3(req_func3),
    .req_a(req_a), .req_b(req_b), .alu_control(alu_control), .alu_a(alu_a),
    .alu_b(alu_b), .alu_cin(alu_cin), .alu_result(alu_result), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .flag_c(flag_c), .flag_z(flag_z), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW:0] alu_ref(input logic [3:0] code, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b, input logic cin);
    logic [DW-1:0] p;
    p = a * b;
    case (code)
      4'd0:       return {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
      4'd1:       return {1'b0, a} + {1'b0, b};
      4'd2:       return {1'b0, a} + {1'b0, ~b} + {{DW{1'b0}}, cin};
      4'd3, 4'd8: return {1'b0, a} + {1'b0, ~b} + 1;
      4'd4:       return {1'b0, b} + {1'b0, ~a} + 1;
      4'd5:       return {1'b0, p};
      4'd6:       return {1'b0, a & b};
      4'd7:       return {1'b0, a | b};
      default:    return '0;
    endcase
  endfunction

  // External ALU stub: a multiply only becomes correct on its last required cycle.
  always @(posedge clk) mul_k <= (alu_control == 4'd5) ? mul_k + 1 : 0;
  always_comb begin
    logic [DW:0] s;
    s = alu_ref(alu_control, alu_a, alu_b, alu_cin);
    if (alu_control == 4'd5 && mul_k != MC - 1) s[DW-1:0] = s[DW-1:0] ^ DW'(32'hDEAD_BEEF);
    alu_result = s[DW-1:0];
    alu_cout   = s[DW];
  end

  function automatic logic [3:0] ref_code(input logic [1:0] op, input logic f7, input logic [2:0] f3);
    if (op == 2'b01) return 4'd1;
    if (op != 2'b10) return 4'd0;
    case ({f7, f3})
      4'b1000: return 4'd1;  4'b0001: return 4'd2;  4'b1001: return 4'd3;
      4'b1010: return 4'd4;  4'b1011: return 4'd5;  4'b0111: return 4'd6;
      4'b0110: return 4'd7;  4'b1111: return 4'd8;  default: return 4'd0;
    endcase
  endfunction

  task automatic do_op(input logic [1:0] op, input logic f7, input logic [2:0] f3,
                       input logic [DW-1:0] a, input logic [DW-1:0] b, input int hold);
    logic [3:0]  code;
    logic        cin;
    logic [DW:0] r;
    int          lat, exp_lat;
    code    = ref_code(op, f7, f3);
    cin     = (code == 4'd0 || code == 4'd2) ? m_c : 1'b0;
    r       = alu_ref(code, a, b, cin);
    exp_lat = (code == 4'd5) ? 1 + MC : 2;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL ready_idle got=%0b exp=1", req_ready); end
    req_valid = 1'b1; req_opcode = op; req_func7 = f7; req_func3 = f3; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom;
    checks++; if (alu_control !== code) begin failures++; $display("FAIL exec_code got=%0d exp=%0d", alu_control, code); end
    checks++; if (alu_a !== a || alu_b !== b) begin failures++; $display("FAIL exec_operands got=%0h/%0h exp=%0h/%0h", alu_a, alu_b, a, b); end
    checks++; if (alu_cin !== cin) begin failures++; $display("FAIL exec_cin got=%0b exp=%0b", alu_cin, cin); end
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 64) begin
      checks++;
      if (alu_control !== code || req_ready !== 1'b0 || busy !== 1'b1) begin
        failures++; $display("FAIL busy_drive got=ctl%0d rdy%0b busy%0b exp=ctl%0d rdy0 busy1", alu_control, req_ready, busy, code);
      end
      @(negedge clk); lat++;
    end
    checks++; if (lat != exp_lat) begin failures++; $display("FAIL latency got=%0d exp=%0d", lat, exp_lat); end
    if (op == 2'b10) begin
      m_z = (r[DW-1:0] == '0);
      if (code <= 4'd4) m_c = r[DW];
    end
    checks++; if (rsp_result !== r[DW-1:0]) begin failures++; $display("FAIL result got=%0h exp=%0h", rsp_result, r[DW-1:0]); end
    checks++; if (flag_c !== m_c || flag_z !== m_z) begin failures++; $display("FAIL flags got=C%0b Z%0b exp=C%0b Z%0b", flag_c, flag_z, m_c, m_z); end
    checks++; if (alu_control !== 4'd0) begin failures++; $display("FAIL resp_ctl got=%0d exp=0", alu_control); end
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'($urandom); req_opcode = 2'($urandom);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== r[DW-1:0] || req_ready !== 1'b0) begin
        failures++; $display("FAIL resp_hold got=v%0b %0h rdy%0b exp=v1 %0h rdy0", rsp_valid, rsp_result, req_ready, r[DW-1:0]);
      end
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL after_hs got=busy%0b v%0b exp=0 0", busy, rsp_valid); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_opcode = '0;
    req_func7 = 1'b0; req_func3 = '0; req_a = '0; req_b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 0 || rsp_valid !== 0 || flag_c !== 0 || flag_z !== 0 || alu_control !== 0 ||
        alu_a !== 0 || alu_b !== 0 || rsp_result !== 0 || req_ready !== 1) begin
      failures++; $display("FAIL reset_state got=busy%0b v%0b C%0b Z%0b ctl%0d a%0h r%0h exp=all0 ready1",
                           busy, rsp_valid, flag_c, flag_z, alu_control, alu_a, rsp_result);
    end
    rst_n = 1'b1; m_c = 1'b0; m_z = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_op(2'b10, 1'b1, 3'b000, 32'd5, 32'd7, 0);
    do_op(2'b10, 1'b1, 3'b000, 32'hFFFF_FFFF, 32'd2, 0);
    do_op(2'b10, 1'b0, 3'b000, 32'd10, 32'd20, 1);
    do_op(2'b10, 1'b0, 3'b111, 32'hF0F0_0000, 32'h0F0F_FFFF, 0);
  endtask

  task automatic test_muls();
    do_op(2'b10, 1'b1, 3'b011, 32'd1234, 32'd5678, 0);
    do_op(2'b10, 1'b1, 3'b011, 32'd0, 32'd99, 2);
  endtask

  task automatic test_resp_hold();
    do_op(2'b10, 1'b1, 3'b001, 32'd3, 32'd9, 3);
  endtask

  task automatic test_abort_mul();
    do_op(2'b10, 1'b1, 3'b000, 32'h8000_0000, 32'h8000_0000, 0);
    req_valid = 1'b1; req_opcode = 2'b10; req_func7 = 1'b1; req_func3 = 3'b011;
    req_a = 32'd7; req_b = 32'd6;
    @(negedge clk); req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b1 || alu_control !== 4'd5) begin failures++; $display("FAIL mulw_before_rst got=busy%0b ctl%0d exp=1 5", busy, alu_control); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; m_c = 1'b0; m_z = 1'b0;
    checks++;
    if (busy !== 0 || rsp_valid !== 0 || flag_c !== 0 || flag_z !== 0 || alu_control !== 0 || alu_a !== 0) begin
      failures++; $display("FAIL abort_state got=busy%0b v%0b C%0b Z%0b ctl%0d a%0h exp=all0", busy, rsp_valid, flag_c, flag_z, alu_control, alu_a);
    end
    for (int i = 0; i < MC + 3; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abort_no_rsp got=v%0b busy%0b exp=0 0", rsp_valid, busy); end
    end
  endtask

  task automatic test_opcodes();
    do_op(2'b10, 1'b1, 3'b000, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(2'b01, 1'b1, 3'b011, 32'd4, 32'd4, 0);
    do_op(2'b11, 1'b0, 3'b001, 32'd1, 32'd2, 0);
    do_op(2'b10, 1'b0, 3'b010, 32'd8, 32'd8, 0);
  endtask

  task automatic test_random();
    logic [3:0] combos [9] = '{4'b0000, 4'b1000, 4'b0001, 4'b1001, 4'b1010,
                               4'b1011, 4'b0111, 4'b0110, 4'b1111};
    logic [3:0] ff;
    logic [1:0] op;
    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 9) < 7) ? 2'b10 : 2'($urandom);
      ff = ($urandom_range(0, 1) == 0) ? combos[$urandom_range(0, 8)] : 4'($urandom);
      do_op(op, ff[3], ff[2:0], ($urandom_range(0, 4) == 0) ? '0 : DW'($urandom),
            DW'($urandom), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_muls();
    test_resp_hold();
    test_abort_mul();
    test_opcodes();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
